traffic_sched: RTL and testbench
================================

# traffic_sched

Demand-driven phase scheduler for a two-road intersection with a pedestrian phase and emergency preemption. It consumes the 1-second `tick` strobe from `tick1s` and sequences the NS/EW lamp outputs. Green time adapts to vehicle presence, and pending pedestrian and emergency requests are folded into the phase order. It replaces the fixed-cycle `traffic` sequencer at the same position in the design.

## Interface
Parameters (all in ticks):
- `GREEN_MIN`, 5, minimum green before yielding to opposing demand
- `GREEN_MAX`, 15, maximum green when own side keeps requesting
- `YELLOW_T`, 3, yellow duration
- `ALLRED_T`, 1, all-red clearance duration
- `WALK_T`, 4, pedestrian walk duration

Ports:
- `clk` in 1: single clock
- `reset` in 1: synchronous, active-high
- `tick` in 1: one-`clk` pulse, once per second
- `ns_req` in 1: NS vehicle present (level)
- `ew_req` in 1: EW vehicle present (level)
- `ped_req` in 1: pedestrian button (any-width pulse, latched)
- `emerg_ns` in 1: NS emergency preempt (level)
- `emerg_ew` in 1: EW emergency preempt (level)
- `ns_green`, `ns_yellow`, `ns_red` out 1: NS lamps, exactly one high
- `ew_green`, `ew_yellow`, `ew_red` out 1: EW lamps, exactly one high
- `walk` out 1: pedestrian walk lamp
- `phase` out 3: current state encoding, for debug

## Operation
- States: `NS_G`, `NS_Y`, `AR`, `EW_G`, `EW_Y`, `WALK`.
- `next_dir` register: selects which green follows `AR` or `WALK`.
  - Set to EW on leaving `NS_Y`.
  - Set to NS on leaving `EW_Y`.
- `tmr`: counts ticks in the current state.
  - Cleared on every state change.
  - Incremented on each `tick` otherwise.
  - Saturates at `GREEN_MAX`. Width is `$clog2(GREEN_MAX+1)`.
- "Elapsed(T)": true on a `tick` cycle when `tmr+1 >= T`. A state timed by T therefore lasts exactly T ticks.
- `ped_pend`:
  - Set on any cycle `ped_req`=1.
  - Cleared on entry to `WALK`.
  - `ped_req` while in `WALK`, or on the entry cycle, is ignored.
- Green exit (shown for `NS_G`; `EW_G` is symmetric). Leave to `NS_Y` on a tick when any of these holds:
  - opposing emergency (`emerg_ew` and not `emerg_ns`), regardless of `tmr`
  - Elapsed(`GREEN_MIN`) and (`ew_req` or `ped_pend`) and not `ns_req`
  - Elapsed(`GREEN_MAX`) and (`ew_req` or `ped_pend`)
- Green hold:
  - With no opposing demand, green holds indefinitely.
  - Own-side emergency blocks exit.
- Yellow: after Elapsed(`YELLOW_T`), go to `AR`.
- `AR`: after Elapsed(`ALLRED_T`):
  - go to `WALK` if `ped_pend` and no emergency is active
  - otherwise go to `next_dir` green
  - if an emergency is active, go to that side's green (NS wins ties)
- `WALK`:
  - All vehicle lamps red, `walk`=1.
  - After Elapsed(`WALK_T`), go to `next_dir` green.
  - Any emergency on a tick goes to `AR` immediately.
- Both emergencies asserted: NS has priority.
- All transitions occur only on cycles with `tick`=1.
- Lamp outputs and `walk` are a combinational decode of the state register, so they change the `clk` edge after the transition tick.
- Lamps:
  - `AR` and `WALK`: both reds high.
  - `NS_G`/`NS_Y`: `ew_red`=1.
  - `EW_G`/`EW_Y`: `ns_red`=1.

## Timing
- Reset values:
  - state `NS_G`, so `ns_green`=1 and `ew_red`=1
  - all other lamps 0, `walk`=0
  - `tmr`=0, `ped_pend`=0, `next_dir`=EW
- Reset asserted mid-phase returns to `NS_G` on the next `clk` edge, regardless of `tick`.
- Request-to-response latency: decisions sample `*_req`/`emerg_*` on the tick cycle itself. A request that drops before the tick is not seen, except `ped_req`, which is latched.
- Minimum full cycle with continuous cross demand and no pedestrians: 2×(5+3+1)=18 ticks.

## Structure
- `traffic_pkg`: state enum, `phase` encodings, default timing localparams. Shared with `traffic` and the test bench.
- Sub-module `phase_timer`: tick counter with clear, saturation, and an `elapsed(T)` compare. It is instantiated once, and the FSM muxes T per state.
- `tick1s` stays external; this block has no prescaler.

## Test plan
- Reset, then 30 ticks with no requests → `ns_green`=1 and `ew_red`=1 throughout; `walk`=0.
- `ew_req`=1 from tick 2, `ns_req`=0 → `ns_yellow` after tick 5 and lasts 3 ticks; `AR` 1 tick; `ew_green` after tick 9.
- `ew_req` and `ns_req` both held → NS green extends to tick 15; `EW_G` begins after tick 19.
- 1-cycle `ped_req` pulse during `NS_G` with no vehicles → after `GREEN_MIN`: `NS_Y`, `AR`, then `WALK` for 4 ticks, then `EW_G`. A second `ped_req` during `WALK` causes no second walk.
- In `EW_G` at tick 1, assert `emerg_ns` → `EW_Y` on the next tick, then `AR`, then `NS_G`. Also: `emerg_ew` asserted during `WALK` → `AR` next tick. Both emergencies asserted in `AR` → `NS_G`.
- Assert `reset` for 1 cycle during `EW_Y` → `NS_G` with `ped_pend` cleared on the following edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection sequencers: phase encodings,
// approach direction and default timing (in 1-second ticks).
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR   = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        WALK = 3'd5
    } phase_e;

    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } dir_e;

    localparam int GREEN_MIN_DEF = 5;
    localparam int GREEN_MAX_DEF = 15;
    localparam int YELLOW_T_DEF  = 3;
    localparam int ALLRED_T_DEF  = 1;
    localparam int WALK_T_DEF    = 4;

endpackage

// File: rtl/phase_timer.sv
// Per-phase tick counter: cleared on phase change, saturating at MAX,
// with a single "this tick completes T ticks" compare.
module phase_timer #(
    parameter int MAX = 15,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         clr,
    input  logic [W-1:0] thresh,
    output logic         elapsed
);

    localparam logic [W:0] ONE = 1;

    logic [W-1:0] r_tmr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmr <= '0;
        end else if (clr) begin
            r_tmr <= '0;
        end else if (tick && (r_tmr != W'(MAX))) begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    // One bit wider so tmr+1 cannot wrap when saturated.
    assign elapsed = tick && (({1'b0, r_tmr} + ONE) >= {1'b0, thresh});

endmodule

// File: rtl/traffic_sched.sv
// Demand-driven intersection scheduler: adaptive greens, latched pedestrian
// phase and emergency preemption, advanced only on the 1-second tick.
module traffic_sched
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = GREEN_MIN_DEF,
    parameter int GREEN_MAX = GREEN_MAX_DEF,
    parameter int YELLOW_T  = YELLOW_T_DEF,
    parameter int ALLRED_T  = ALLRED_T_DEF,
    parameter int WALK_T    = WALK_T_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ns_req,
    input  logic       ew_req,
    input  logic       ped_req,
    input  logic       emerg_ns,
    input  logic       emerg_ew,
    output logic       ns_green,
    output logic       ns_yellow,
    output logic       ns_red,
    output logic       ew_green,
    output logic       ew_yellow,
    output logic       ew_red,
    output logic       walk,
    output logic [2:0] phase
);

    localparam int TW = $clog2(GREEN_MAX + 1);

    phase_e          r_state;
    phase_e          w_state_next;
    dir_e            r_next_dir;
    logic            r_ped_pend;
    logic [TW-1:0]   w_thresh;
    logic            w_elapsed;
    logic            w_clr;

    assign w_clr = (w_state_next != r_state);

    phase_timer #(
        .MAX (GREEN_MAX),
        .W   (TW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .clr     (w_clr),
        .thresh  (w_thresh),
        .elapsed (w_elapsed)
    );

    // Green uses GREEN_MAX while its own side still requests, else GREEN_MIN;
    // the early exit then only needs one compare.
    always_comb begin
        w_state_next = r_state;
        w_thresh     = TW'(GREEN_MIN);
        case (r_state)
            NS_G: begin
                w_thresh = ns_req ? TW'(GREEN_MAX) : TW'(GREEN_MIN);
                if (tick && ((emerg_ew && !emerg_ns) ||
                             (!emerg_ns && (ew_req || r_ped_pend) && w_elapsed)))
                    w_state_next = NS_Y;
            end
            EW_G: begin
                w_thresh = ew_req ? TW'(GREEN_MAX) : TW'(GREEN_MIN);
                if (tick && (emerg_ns ||
                             (!emerg_ew && (ns_req || r_ped_pend) && w_elapsed)))
                    w_state_next = EW_Y;
            end
            NS_Y: begin
                w_thresh = TW'(YELLOW_T);
                if (w_elapsed) w_state_next = AR;
            end
            EW_Y: begin
                w_thresh = TW'(YELLOW_T);
                if (w_elapsed) w_state_next = AR;
            end
            AR: begin
                w_thresh = TW'(ALLRED_T);
                if (w_elapsed) begin
                    if (emerg_ns)                  w_state_next = NS_G;
                    else if (emerg_ew)             w_state_next = EW_G;
                    else if (r_ped_pend)           w_state_next = WALK;
                    else if (r_next_dir == DIR_NS) w_state_next = NS_G;
                    else                           w_state_next = EW_G;
                end
            end
            WALK: begin
                w_thresh = TW'(WALK_T);
                if (tick && (emerg_ns || emerg_ew))
                    w_state_next = AR;
                else if (w_elapsed)
                    w_state_next = (r_next_dir == DIR_NS) ? NS_G : EW_G;
            end
            default: w_state_next = NS_G;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= NS_G;
            r_next_dir <= DIR_EW;
            r_ped_pend <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == NS_Y && w_state_next != NS_Y) r_next_dir <= DIR_EW;
            if (r_state == EW_Y && w_state_next != EW_Y) r_next_dir <= DIR_NS;
            // Presses during the walk (or on its entry cycle) are already served.
            if (w_state_next == WALK && r_state != WALK)
                r_ped_pend <= 1'b0;
            else if (ped_req && r_state != WALK)
                r_ped_pend <= 1'b1;
        end
    end

    always_comb begin
        ns_green  = 1'b0;
        ns_yellow = 1'b0;
        ns_red    = 1'b0;
        ew_green  = 1'b0;
        ew_yellow = 1'b0;
        ew_red    = 1'b0;
        walk      = 1'b0;
        case (r_state)
            NS_G:    begin ns_green  = 1'b1; ew_red = 1'b1; end
            NS_Y:    begin ns_yellow = 1'b1; ew_red = 1'b1; end
            EW_G:    begin ew_green  = 1'b1; ns_red = 1'b1; end
            EW_Y:    begin ew_yellow = 1'b1; ns_red = 1'b1; end
            WALK:    begin ns_red = 1'b1; ew_red = 1'b1; walk = 1'b1; end
            default: begin ns_red = 1'b1; ew_red = 1'b1; end
        endcase
    end

    assign phase = r_state;

endmodule

// File: tb/tb_traffic_sched.sv
// Scoreboard bench for traffic_sched: the driver queues the phase expected
// after each tick (or probe), a monitor pops and checks phase and lamps.
module tb_traffic_sched;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       ns_req = 1'b0;
    logic       ew_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       emerg_ns = 1'b0;
    logic       emerg_ew = 1'b0;
    logic       ns_green, ns_yellow, ns_red;
    logic       ew_green, ew_yellow, ew_red;
    logic       walk;
    logic [2:0] phase;
    logic       probe = 1'b0;

    typedef struct {
        phase_e ph;
        int     id;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    logic [6:0] mon_lamps;
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_id = 0;

    traffic_sched dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .ns_req    (ns_req),
        .ew_req    (ew_req),
        .ped_req   (ped_req),
        .emerg_ns  (emerg_ns),
        .emerg_ew  (emerg_ew),
        .ns_green  (ns_green),
        .ns_yellow (ns_yellow),
        .ns_red    (ns_red),
        .ew_green  (ew_green),
        .ew_yellow (ew_yellow),
        .ew_red    (ew_red),
        .walk      (walk),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    // {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
    function automatic logic [6:0] lamps_of(input phase_e p);
        case (p)
            NS_G:    return 7'b100_001_0;
            NS_Y:    return 7'b010_001_0;
            EW_G:    return 7'b001_100_0;
            EW_Y:    return 7'b001_010_0;
            WALK:    return 7'b001_001_1;
            default: return 7'b001_001_0;
        endcase
    endfunction

    // Monitor: one transaction per tick or probe cycle.
    initial begin
        forever begin
            @(posedge clk);
            if (tick || probe) begin
                @(negedge clk);
                mon_lamps = {ns_green, ns_yellow, ns_red, ew_green, ew_yellow, ew_red, walk};
                n_chk++;
                if (q.size() == 0) begin
                    $display("FAIL scoreboard_empty got phase %0d with no expected entry", phase);
                end else begin
                    mon_e = q.pop_front();
                    if (phase === mon_e.ph) n_pass++;
                    else $display("FAIL phase#%0d got %0d want %0d", mon_e.id, phase, mon_e.ph);
                    n_chk++;
                    if (mon_lamps === lamps_of(mon_e.ph)) n_pass++;
                    else $display("FAIL lamps#%0d got %b want %b", mon_e.id, mon_lamps,
                                  lamps_of(mon_e.ph));
                    $display("txn %0d phase=%0d lamps=%b", mon_e.id, phase, mon_lamps);
                end
            end
        end
    end

    task automatic expect_ph(input phase_e ph);
        exp_t e;
        e.ph = ph;
        e.id = n_id;
        n_id++;
        q.push_back(e);
    endtask

    task automatic idle;
        @(posedge clk);
        #1;
    endtask

    task automatic tk(input phase_e ph);
        expect_ph(ph);
        tick = 1'b1;
        idle();
        tick = 1'b0;
        idle();
    endtask

    task automatic tks(input phase_e ph, input int n);
        for (int i = 0; i < n; i++) tk(ph);
    endtask

    task automatic do_reset;
        ns_req = 0; ew_req = 0; ped_req = 0; emerg_ns = 0; emerg_ew = 0;
        reset = 1'b1;
        repeat (2) idle();
        reset = 1'b0;
        expect_ph(NS_G);
        probe = 1'b1;
        idle();
        probe = 1'b0;
        idle();
    endtask

    task automatic pulse_ped;
        ped_req = 1'b1;
        idle();
        ped_req = 1'b0;
        idle();
    endtask

    task automatic mid_reset;
        expect_ph(NS_G);
        reset = 1'b1;
        probe = 1'b1;
        idle();
        reset = 1'b0;
        probe = 1'b0;
        idle();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired after %0d of %0d checks", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        // Idle intersection: NS green forever.
        do_reset();
        tks(NS_G, 30);

        // EW demand from tick 2, then NS emergency at EW_G tick 1.
        do_reset();
        tk(NS_G);
        ew_req = 1;
        tks(NS_G, 3);
        tk(NS_Y); tks(NS_Y, 2);
        tk(AR);
        tk(EW_G); tk(EW_G);
        emerg_ns = 1;
        tk(EW_Y); tks(EW_Y, 2);
        tk(AR);
        tk(NS_G);
        emerg_ns = 0; ew_req = 0;
        tks(NS_G, 3);

        // Both sides requesting: greens stretch to GREEN_MAX.
        do_reset();
        ns_req = 1; ew_req = 1;
        tks(NS_G, 14);
        tk(NS_Y); tks(NS_Y, 2);
        tk(AR);
        tk(EW_G); tks(EW_G, 14);
        tk(EW_Y); tks(EW_Y, 2);
        tk(AR);
        tk(NS_G);
        ns_req = 0; ew_req = 0;

        // Pedestrian phase; second press during WALK is ignored.
        do_reset();
        pulse_ped();
        tks(NS_G, 4);
        tk(NS_Y); tks(NS_Y, 2);
        tk(AR);
        tk(WALK); tk(WALK);
        pulse_ped();
        tks(WALK, 2);
        tk(EW_G); tks(EW_G, 7);

        // Emergency during WALK, then both emergencies in AR.
        do_reset();
        pulse_ped();
        tks(NS_G, 4);
        tk(NS_Y); tks(NS_Y, 2);
        tk(AR);
        tk(WALK); tk(WALK);
        emerg_ew = 1;
        tk(AR);
        emerg_ns = 1;
        tk(NS_G);
        emerg_ns = 0; emerg_ew = 0;
        tks(NS_G, 2);

        // Reset in EW_Y drops a pending pedestrian request.
        do_reset();
        ew_req = 1;
        tks(NS_G, 4);
        tk(NS_Y); tks(NS_Y, 2);
        tk(AR);
        tk(EW_G);
        ew_req = 0; ns_req = 1;
        tks(EW_G, 4);
        tk(EW_Y);
        ns_req = 0;
        pulse_ped();
        mid_reset();
        tks(NS_G, 8);

        idle();
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain got %0d entries left want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
